// File: rtl/afu_rd_arbiter_if.sv
// afu_rd_arbiter_if
//   Bundles the requester-side, SPL-side and response-side signals of the
//   AFU read-request arbiter.
//   slave  : the arbiter itself (drives req_ready, afu_tx_rd_*, rsp_*,
//            outstanding, err_bad_tag).
//   master : the environment (fetch units + SPL) driving requests, the
//            almost-full flag and read responses.
//   req_hdr is packed so requester i sits at [i*TXHDR_WIDTH +: TXHDR_WIDTH].
interface afu_rd_arbiter_if #(
  parameter int NUM_REQ     = 2,
  parameter int TXHDR_WIDTH = 99,
  parameter int RXHDR_WIDTH = 24,
  parameter int CACHE_WIDTH = 512
);
  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0][TXHDR_WIDTH-1:0] req_hdr;
  logic [NUM_REQ-1:0]                  req_ready;
  logic                                spl_tx_rd_almostfull;
  logic                                afu_tx_rd_valid;
  logic [TXHDR_WIDTH-1:0]              afu_tx_rd_hdr;
  logic                                spl_rx_rd_valid;
  logic [RXHDR_WIDTH-1:0]              spl_rx_hdr0;
  logic [CACHE_WIDTH-1:0]              spl_rx_data;
  logic [NUM_REQ-1:0]                  rsp_valid;
  logic [CACHE_WIDTH-1:0]              rsp_data;
  logic [11:0]                         rsp_seq;
  logic [NUM_REQ-1:0][6:0]             outstanding;
  logic                                err_bad_tag;

  modport slave (
    input  req_valid, req_hdr, spl_tx_rd_almostfull,
           spl_rx_rd_valid, spl_rx_hdr0, spl_rx_data,
    output req_ready, afu_tx_rd_valid, afu_tx_rd_hdr,
           rsp_valid, rsp_data, rsp_seq, outstanding, err_bad_tag
  );

  modport master (
    output req_valid, req_hdr, spl_tx_rd_almostfull,
           spl_rx_rd_valid, spl_rx_hdr0, spl_rx_data,
    input  req_ready, afu_tx_rd_valid, afu_tx_rd_hdr,
           rsp_valid, rsp_data, rsp_seq, outstanding, err_bad_tag
  );
endinterface

// File: rtl/afu_rd_arbiter.sv
// afu_rd_arbiter
//   Shares the AFU TX read-request channel between NUM_REQ fetch units with
//   round-robin fairness, per-requester outstanding limits and almost-full
//   backpressure, and steers read responses back by tag.
//   Tag format on the wire: [13:12] requester id, [11:0] per-requester seq.
// Ports
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : afu_rd_arbiter_if.slave (request, SPL and response signals)

// Per-requester bookkeeping: sequence counter and in-flight count.
//   grant     : this requester won arbitration this cycle
//   rsp_hit   : a response addressed to this requester arrived this cycle
//   below_max : room for another outstanding read
//   underflow : response arrived while nothing was in flight
module afu_rd_arbiter_lane #(
  parameter int MAX_OUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        grant,
  input  logic        rsp_hit,
  output logic        below_max,
  output logic        underflow,
  output logic [11:0] seq,
  output logic [6:0]  outstanding
);
  logic dec;

  assign below_max = outstanding < 7'(MAX_OUT);
  assign underflow = rsp_hit && (outstanding == 7'd0);
  // A response with nothing in flight is flagged, never decremented.
  assign dec       = rsp_hit && (outstanding != 7'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq         <= '0;
      outstanding <= '0;
    end else begin
      if (grant) seq <= seq + 12'd1;  // wraps 4095 -> 0
      if (grant && !dec)      outstanding <= outstanding + 7'd1;
      else if (!grant && dec) outstanding <= outstanding - 7'd1;
    end
  end
endmodule

module afu_rd_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TXHDR_WIDTH = 99,
  parameter int RXHDR_WIDTH = 24,
  parameter int CACHE_WIDTH = 512,
  parameter int MAX_OUT     = 16
) (
  input logic            clk,
  input logic            reset_n,
  afu_rd_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]              last_grant;
  logic [NUM_REQ-1:0]         below_max;
  logic [NUM_REQ-1:0]         underflow;
  logic [NUM_REQ-1:0]         elig;
  logic [NUM_REQ-1:0]         grant;
  logic [NUM_REQ-1:0]         rsp_hit;
  logic [NUM_REQ-1:0][11:0]   seq;
  logic [NUM_REQ-1:0][6:0]    out_cnt;
  logic [PW-1:0]              gnt_idx;
  logic                       gnt_any;
  logic [TXHDR_WIDTH-1:0]     tx_hdr_nxt;
  logic [1:0]                 rx_id;
  logic                       id_ok;
  int                         cand;

  // ---------------- arbitration ----------------
  // Search starts one past the last winner; the pointer moves only on a
  // grant so a stalled cycle (almost-full) never skips anyone.
  always_comb begin
    elig    = bus.req_valid & below_max & {NUM_REQ{~bus.spl_tx_rd_almostfull}};
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!gnt_any && elig[cand]) begin
        gnt_any     = 1'b1;
        gnt_idx     = PW'(cand);
        grant[cand] = 1'b1;
      end
    end
    // No handshakes while reset is held.
    if (!reset_n) begin
      grant   = '0;
      gnt_any = 1'b0;
    end
  end

  assign bus.req_ready = grant;

  // Outgoing header keeps the requester's upper bits; the tag field is
  // replaced so the response can be routed back without a lookup table.
  always_comb begin
    tx_hdr_nxt        = bus.req_hdr[gnt_idx];
    tx_hdr_nxt[13:0]  = {2'(gnt_idx), seq[gnt_idx]};
  end

  // ---------------- response steering ----------------
  assign rx_id = bus.spl_rx_hdr0[13:12];
  assign id_ok = int'(rx_id) < NUM_REQ;

  // ---------------- per-requester lanes ----------------
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign rsp_hit[g] = bus.spl_rx_rd_valid && id_ok && (rx_id == 2'(g));

    afu_rd_arbiter_lane #(.MAX_OUT(MAX_OUT)) u_lane (
      .clk         (clk),
      .reset_n     (reset_n),
      .grant       (grant[g]),
      .rsp_hit     (rsp_hit[g]),
      .below_max   (below_max[g]),
      .underflow   (underflow[g]),
      .seq         (seq[g]),
      .outstanding (out_cnt[g])
    );
  end

  assign bus.outstanding = out_cnt;

  // ---------------- output registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant          <= PW'(NUM_REQ - 1);
      bus.afu_tx_rd_valid <= 1'b0;
      bus.afu_tx_rd_hdr   <= '0;
      bus.rsp_valid       <= '0;
      bus.rsp_data        <= '0;
      bus.rsp_seq         <= '0;
      bus.err_bad_tag     <= 1'b0;
    end else begin
      bus.afu_tx_rd_valid <= gnt_any;
      if (gnt_any) begin
        bus.afu_tx_rd_hdr <= tx_hdr_nxt;
        last_grant        <= gnt_idx;
      end
      bus.rsp_valid <= rsp_hit;
      // Data/seq hold until the next accepted response.
      if (|rsp_hit) begin
        bus.rsp_data <= bus.spl_rx_data;
        bus.rsp_seq  <= bus.spl_rx_hdr0[11:0];
      end
      // Sticky: unknown requester id or a response nobody was waiting for.
      if ((bus.spl_rx_rd_valid && !id_ok) || (|underflow))
        bus.err_bad_tag <= 1'b1;
    end
  end
endmodule

// File: tb/tb_afu_rd_arbiter.sv
module tb_afu_rd_arbiter;
  localparam int NUM_REQ = 2;
  localparam int TXW     = 99;
  localparam int RXW     = 24;
  localparam int CW      = 512;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  afu_rd_arbiter_if #(.NUM_REQ(NUM_REQ), .TXHDR_WIDTH(TXW), .RXHDR_WIDTH(RXW),
                      .CACHE_WIDTH(CW)) bus ();

  afu_rd_arbiter #(.NUM_REQ(NUM_REQ), .TXHDR_WIDTH(TXW), .RXHDR_WIDTH(RXW),
                   .CACHE_WIDTH(CW), .MAX_OUT(MAX_OUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int wraps = 0;

  typedef struct {
    logic [NUM_REQ-1:0] onehot;
    logic [CW-1:0]      data;
    logic [11:0]        seq;
  } rsp_t;

  // Reference model: issued-but-unanswered tags, counts, seq and pointer.
  logic [TXW-1:0] exp_tx[$];
  rsp_t           exp_rsp[$];
  logic [13:0]    infl[$];
  int             cnt[NUM_REQ];
  int             m_seq[NUM_REQ];
  int             m_ptr;
  bit             m_err;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_tx.delete();
    exp_rsp.delete();
    infl.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt[i]   = 0;
      m_seq[i] = 0;
    end
    m_ptr = NUM_REQ - 1;
    m_err = 1'b0;
  endtask

  // kind: 0 none, 1 random in-flight tag, 2 explicit tag, 3 oldest of req 0
  task automatic drive_cycle(input logic [NUM_REQ-1:0] rv, input logic af,
                             input int kind, input logic [13:0] tag_in);
    logic [13:0]        tag;
    logic [TXW-1:0]     e;
    logic [NUM_REQ-1:0] exp_rdy;
    rsp_t               r;
    bit                 do_rsp;
    int                 g, j, id, fidx;
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++)
      bus.req_hdr[i] = TXW'({$urandom(), $urandom(), $urandom(), $urandom()});
    for (int w = 0; w < CW / 32; w++) bus.spl_rx_data[w*32 +: 32] = $urandom();
    bus.req_valid            = rv;
    bus.spl_tx_rd_almostfull = af;
    do_rsp = 1'b0;
    tag    = tag_in;
    if (kind == 1 && infl.size() > 0) begin
      tag = infl[$urandom_range(infl.size() - 1)];
      do_rsp = 1'b1;
    end else if (kind == 2) begin
      do_rsp = 1'b1;
    end else if (kind == 3) begin
      for (int q = 0; q < infl.size(); q++)
        if (!do_rsp && infl[q][13:12] == 2'd0) begin tag = infl[q]; do_rsp = 1'b1; end
    end
    bus.spl_rx_rd_valid = do_rsp;
    bus.spl_rx_hdr0     = {10'($urandom()), tag};
    // grant from pre-cycle state
    g = -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (m_ptr + k) % NUM_REQ;
      if (g < 0 && rv[j] && cnt[j] < MAX_OUT && !af) g = j;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    #1;
    chk("req_ready", bus.req_ready, exp_rdy);
    if (do_rsp) begin
      id = int'(tag[13:12]);
      if (id >= NUM_REQ) m_err = 1'b1;
      else begin
        r.onehot = '0;
        r.onehot[id] = 1'b1;
        r.data = bus.spl_rx_data;
        r.seq  = tag[11:0];
        exp_rsp.push_back(r);
        if (cnt[id] == 0) m_err = 1'b1;
        else begin
          fidx = -1;
          for (int q = 0; q < infl.size(); q++) if (fidx < 0 && infl[q] == tag) fidx = q;
          for (int q = 0; q < infl.size(); q++)
            if (fidx < 0 && int'(infl[q][13:12]) == id) fidx = q;
          infl.delete(fidx);
          cnt[id]--;
        end
      end
    end
    if (g >= 0) begin
      e = bus.req_hdr[g];
      e[13:0] = {2'(g), 12'(m_seq[g])};
      exp_tx.push_back(e);
      infl.push_back(e[13:0]);
      cnt[g]++;
      m_seq[g] = (m_seq[g] + 1) % 4096;
      m_ptr = g;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents outputs.
  initial begin
    logic [TXW-1:0] e;
    rsp_t           r;
    logic [11:0]    prev0;
    prev0 = 12'h000;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) prev0 = 12'h000;
      if (exp_tx.size() > 0) begin
        e = exp_tx.pop_front();
        chk("tx_valid", bus.afu_tx_rd_valid, 1);
        chk("tx_hdr", bus.afu_tx_rd_hdr, e);
        if (bus.afu_tx_rd_hdr[13:12] == 2'd0) begin
          if (prev0 == 12'hFFF) begin
            wraps++;
            chk("seq_wrap", bus.afu_tx_rd_hdr[11:0], 0);
          end
          prev0 = bus.afu_tx_rd_hdr[11:0];
        end
      end else chk("tx_valid_idle", bus.afu_tx_rd_valid, 0);
      if (exp_rsp.size() > 0) begin
        r = exp_rsp.pop_front();
        chk("rsp_valid", bus.rsp_valid, r.onehot);
        chk("rsp_data", bus.rsp_data, r.data);
        chk("rsp_seq", bus.rsp_seq, r.seq);
      end else chk("rsp_valid_idle", bus.rsp_valid, 0);
      for (int i = 0; i < NUM_REQ; i++) chk("outstanding", bus.outstanding[i], cnt[i]);
      chk("err_bad_tag", bus.err_bad_tag, m_err);
    end
  end

  initial begin
    model_reset();
    bus.req_valid = '0;
    bus.req_hdr = '0;
    bus.spl_tx_rd_almostfull = 1'b0;
    bus.spl_rx_rd_valid = 1'b0;
    bus.spl_rx_hdr0 = '0;
    bus.spl_rx_data = '0;
    #12;
    chk("rst_tx_valid", bus.afu_tx_rd_valid, 0);
    chk("rst_tx_hdr", bus.afu_tx_rd_hdr, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_seq", bus.rsp_seq, 0);
    bus.req_valid = '1;
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    bus.req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;

    // alternating grants, tags 0x0000 0x1000 0x0001 0x1001
    repeat (4) drive_cycle(2'b11, 1'b0, 0, 14'h0);
    repeat (6) drive_cycle(2'b00, 1'b0, 1, 14'h0);

    // outstanding limit on requester 1
    repeat (6) drive_cycle(2'b10, 1'b0, 0, 14'h0);
    chk("max_out_cnt1", bus.outstanding[1], 4);
    drive_cycle(2'b10, 1'b0, 2, 14'h1002);
    drive_cycle(2'b10, 1'b0, 0, 14'h0);
    chk("rsp_1002_valid", bus.rsp_valid, 2'b10);
    chk("rsp_1002_seq", bus.rsp_seq, 2);
    repeat (8) drive_cycle(2'b00, 1'b0, 1, 14'h0);

    // almost-full stall and resume
    repeat (2) drive_cycle(2'b11, 1'b0, 0, 14'h0);
    repeat (5) drive_cycle(2'b11, 1'b1, 0, 14'h0);
    repeat (2) drive_cycle(2'b11, 1'b0, 0, 14'h0);
    repeat (8) drive_cycle(2'b00, 1'b0, 1, 14'h0);

    // same-cycle grant and response on requester 0
    repeat (3) drive_cycle(2'b01, 1'b0, 0, 14'h0);
    drive_cycle(2'b01, 1'b0, 3, 14'h0);
    drive_cycle(2'b00, 1'b0, 0, 14'h0);
    chk("same_cycle_cnt0", bus.outstanding[0], 3);
    chk("same_cycle_rsp", bus.rsp_valid, 2'b01);
    repeat (6) drive_cycle(2'b00, 1'b0, 1, 14'h0);

    // unknown requester id
    drive_cycle(2'b00, 1'b0, 2, 14'h3005);
    drive_cycle(2'b00, 1'b0, 0, 14'h0);
    chk("bad_tag_set", bus.err_bad_tag, 1);
    repeat (3) drive_cycle(2'b00, 1'b0, 0, 14'h0);
    chk("bad_tag_held", bus.err_bad_tag, 1);

    // randomized traffic
    for (int n = 0; n < 400; n++)
      drive_cycle(NUM_REQ'($urandom()), ($urandom_range(7) == 0), $urandom_range(1), 14'h0);
    repeat (10) drive_cycle(2'b00, 1'b0, 1, 14'h0);

    // seq wrap on requester 0
    repeat (4100) drive_cycle(2'b01, 1'b0, 3, 14'h0);
    repeat (4) drive_cycle(2'b00, 1'b0, 1, 14'h0);
    chk("wrap_seen", (wraps > 0), 1);

    // reset pulsed mid-burst
    repeat (20) drive_cycle(2'b01, 1'b0, 3, 14'h0);
    @(negedge clk);
    bus.req_valid = '0;
    bus.spl_rx_rd_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid", bus.afu_tx_rd_valid, 0);
    chk("mid_rst_tx_hdr", bus.afu_tx_rd_hdr, 0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_rsp_data", bus.rsp_data, 0);
    chk("mid_rst_rsp_seq", bus.rsp_seq, 0);
    chk("mid_rst_out0", bus.outstanding[0], 0);
    chk("mid_rst_err", bus.err_bad_tag, 0);
    model_reset();
    bus.req_valid = '1;
    #1;
    chk("mid_rst_req_ready", bus.req_ready, 0);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    bus.req_valid = '0;
    drive_cycle(2'b11, 1'b0, 0, 14'h0);
    chk("first_after_rst", bus.req_ready, 2'b01);
    // response to requester 1 with nothing in flight
    drive_cycle(2'b00, 1'b0, 2, 14'h1000);
    drive_cycle(2'b00, 1'b0, 0, 14'h0);
    chk("zero_cnt_err", bus.err_bad_tag, 1);
    repeat (3) drive_cycle(2'b00, 1'b0, 1, 14'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
